// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Purpose  : Op codes and FSM state encoding shared by the iterative shifter.
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_SHL = 3'd0;
  localparam op_t OP_SHR = 3'd1;
  localparam op_t OP_SAR = 3'd2;
  localparam op_t OP_ROL = 3'd3;
  localparam op_t OP_ROR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Purpose  : Combinational single step: apply op by k (1..STEP) positions.
// Revision : 1.0 - initial release
// ============================================================================
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [2:0]       op,
  input  logic [KW-1:0]    k,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             carry
);

  localparam int SW = $clog2(WIDTH) + 1;
  localparam logic [SW-1:0] c_width = SW'(WIDTH);

  logic [SW-1:0]    w_kx;
  logic [SW-1:0]    w_inv;
  logic [WIDTH:0]   w_ext_l;
  logic [WIDTH:0]   w_ext_r;
  logic [WIDTH:0]   w_ext_a;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;

  // One guard bit beyond the operand catches the last bit pushed out.
  always_comb begin
    w_kx    = SW'(k);
    w_inv   = c_width - w_kx;
    w_ext_l = {1'b0, din} << w_kx;
    w_ext_r = {din, 1'b0} >> w_kx;
    w_ext_a = $unsigned($signed({din, 1'b0}) >>> w_kx);
    w_rol   = (din << w_kx) | (din >> w_inv);
    w_ror   = (din >> w_kx) | (din << w_inv);
  end

  always_comb begin
    dout  = din;
    carry = 1'b0;
    case (op)
      OP_SHL: begin dout = w_ext_l[WIDTH-1:0]; carry = w_ext_l[WIDTH]; end
      OP_SHR: begin dout = w_ext_r[WIDTH:1];   carry = w_ext_r[0];     end
      OP_SAR: begin dout = w_ext_a[WIDTH:1];   carry = w_ext_a[0];     end
      OP_ROL: begin dout = w_rol;              carry = w_rol[0];       end
      OP_ROR: begin dout = w_ror;              carry = w_ror[WIDTH-1]; end
      default: begin dout = din; carry = 1'b0; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_rotate_iter.sv
`default_nettype none
// ============================================================================
// Module   : shift_rotate_iter
// Purpose  : Iterative shift/rotate unit, up to STEP bits per clock.
// Revision : 1.0 - initial release
// ============================================================================
module shift_rotate_iter
  import shift_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   din,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   dout,
  output logic               carry
);

  localparam int KW = $clog2(STEP + 1);
  localparam logic [SHAMT_W:0] c_step = (SHAMT_W + 1)'(STEP);

  state_t             r_state;
  state_t             w_next;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_work;
  logic               r_carry;
  logic [SHAMT_W-1:0] r_rem;
  logic [KW-1:0]      w_k;
  logic [SHAMT_W-1:0] w_k_rem;
  logic [WIDTH-1:0]   w_step_out;
  logic               w_step_carry;
  logic               w_accept;

  always_comb begin
    if ({1'b0, r_rem} >= c_step) begin
      w_k = KW'(STEP);
    end else begin
      w_k = KW'(r_rem);
    end
    w_k_rem = SHAMT_W'(w_k);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .op    (r_op),
    .k     (w_k),
    .din   (r_work),
    .dout  (w_step_out),
    .carry (w_step_carry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid) begin
          w_next = ((shamt == '0) || (op > OP_ROR)) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_rem == w_k_rem) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op    <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_rem   <= '0;
    end else if (w_accept) begin
      r_op    <= op;
      r_work  <= din;
      r_carry <= 1'b0;
      r_rem   <= shamt;
    end else if (r_state == ST_RUN) begin
      r_work  <= w_step_out;
      r_carry <= w_step_carry;
      r_rem   <= r_rem - w_k_rem;
    end
  end

  assign dout  = r_work;
  assign carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_shift_rotate_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_rotate_iter
// Purpose  : Bench for shift_rotate_iter at WIDTH=16, STEP=1 and STEP=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_rotate_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_a  [2];
  logic        in_ready_a  [2];
  logic [2:0]  op_a        [2];
  logic [3:0]  shamt_a     [2];
  logic [15:0] din_a       [2];
  logic        out_valid_a [2];
  logic        out_ready_a [2];
  logic [15:0] dout_a      [2];
  logic        carry_a     [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    shift_rotate_iter #(
      .WIDTH (16),
      .STEP  ((i == 0) ? 1 : 4)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .in_valid  (in_valid_a[i]),
      .in_ready  (in_ready_a[i]),
      .op        (op_a[i]),
      .shamt     (shamt_a[i]),
      .din       (din_a[i]),
      .out_valid (out_valid_a[i]),
      .out_ready (out_ready_a[i]),
      .dout      (dout_a[i]),
      .carry     (carry_a[i])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one-shot shift/rotate of a 16-bit value by s positions.
  function automatic void model(input int opc, input int s, input int d,
                                output int r, output int c);
    int v;
    r = d;
    c = 0;
    if (s != 0) begin
      case (opc)
        0: begin r = (d << s) & 65535;  c = (d >> (16 - s)) & 1; end
        1: begin r = d / (1 << s);      c = (d >> (s - 1)) & 1; end
        2: begin
          v = (d >= 32768) ? d - 65536 : d;
          r = (v >>> s) & 65535;
          c = (d >> (s - 1)) & 1;
        end
        3: begin r = ((d << s) | (d >> (16 - s))) & 65535; c = r & 1; end
        4: begin r = ((d >> s) | (d << (16 - s))) & 65535; c = (r >> 15) & 1; end
        default: begin r = d; c = 0; end
      endcase
    end
  endfunction

  function automatic int latency(input int idx, input int opc, input int s);
    int st;
    st = (idx == 0) ? 1 : 4;
    if (s == 0 || opc > 4) return 0;
    return (s + st - 1) / st;
  endfunction

  // Called at posedge+1; issues one op, waits for result, holds it, releases.
  task automatic do_op(input int idx, input int opc, input int s, input int d,
                       input int hold, input int exp_r, input int exp_c);
    int cnt;
    int lat;
    logic [15:0] held_d;
    logic        held_c;
    lat = latency(idx, opc, s);
    in_valid_a[idx] = 1'b1;
    op_a[idx]       = 3'(opc);
    shamt_a[idx]    = 4'(s);
    din_a[idx]      = 16'(d);
    @(posedge clk);
    #1;
    // Inputs are only sampled at accept; this competing request must be ignored.
    op_a[idx]    = 3'($urandom_range(0, 7));
    shamt_a[idx] = 4'($urandom);
    din_a[idx]   = 16'($urandom);
    cnt = 0;
    while (!out_valid_a[idx] && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk($sformatf("valid[%0d]", idx), 32'(out_valid_a[idx]), 32'd1);
    chk($sformatf("lat[%0d] op%0d s%0d", idx, opc, s), cnt, lat);
    chk($sformatf("dout[%0d] op%0d s%0d d%0h", idx, opc, s, d), 32'(dout_a[idx]), exp_r);
    chk($sformatf("carry[%0d] op%0d s%0d d%0h", idx, opc, s, d), 32'(carry_a[idx]), exp_c);
    held_d = dout_a[idx];
    held_c = carry_a[idx];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid_a[idx]), 32'd1);
      chk("hold_dout", 32'(dout_a[idx]), 32'(held_d));
      chk("hold_carry", 32'(carry_a[idx]), 32'(held_c));
      chk("hold_in_ready", 32'(in_ready_a[idx]), 32'd0);
    end
    in_valid_a[idx]  = 1'b0;
    out_ready_a[idx] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a[idx] = 1'b0;
    chk("release_valid", 32'(out_valid_a[idx]), 32'd0);
    chk("release_in_ready", 32'(in_ready_a[idx]), 32'd1);
  endtask

  task automatic rand_op(input int idx);
    int opc, s, d, r, c;
    opc = $urandom_range(0, 7);
    s   = $urandom_range(0, 15);
    d   = $urandom_range(0, 65535);
    model(opc, s, d, r, c);
    do_op(idx, opc, s, d, $urandom_range(0, 2), r, c);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid_a[i]  = 1'b0;
      op_a[i]        = 3'd0;
      shamt_a[i]     = 4'd0;
      din_a[i]       = 16'd0;
      out_ready_a[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", 32'(out_valid_a[i]), 32'd0);
      chk("rst_dout", 32'(dout_a[i]), 32'd0);
      chk("rst_carry", 32'(carry_a[i]), 32'd0);
      chk("rst_in_ready", 32'(in_ready_a[i]), 32'd1);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 2; i++) begin
      do_op(i, 0, 1, 16'h8001, 0, 16'h0002, 1);
      do_op(i, 2, 15, 16'h8000, 0, 16'hFFFF, 0);
      do_op(i, 4, 4, 16'h55AA, 0, 16'hA55A, 1);
      do_op(i, 3, 1, 16'h7FFF, 0, 16'hFFFE, 0);
      do_op(i, 5, 0, 16'h1234, 0, 16'h1234, 0);
      do_op(i, 1, 0, 16'hBEEF, 0, 16'hBEEF, 0);
      do_op(i, 7, 9, 16'hCAFE, 0, 16'hCAFE, 0);
      do_op(i, 1, 8, 16'hFFFF, 3, 16'h00FF, 1);
    end

    for (int n = 0; n < 40; n++) begin
      rand_op(n % 2);
    end

    // Abandon an operation mid-RUN with an asynchronous reset.
    in_valid_a[0] = 1'b1;
    op_a[0]       = 3'd1;
    shamt_a[0]    = 4'd8;
    din_a[0]      = 16'h1234;
    @(posedge clk);
    #1;
    in_valid_a[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrun_valid", 32'(out_valid_a[0]), 32'd0);
    chk("midrun_dout", 32'(dout_a[0]), 32'd0);
    chk("midrun_carry", 32'(carry_a[0]), 32'd0);
    chk("midrun_in_ready", 32'(in_ready_a[0]), 32'd1);
    in_valid_a[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_a[0] = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_result", 32'(out_valid_a[0]), 32'd0);
    end
    do_op(0, 0, 3, 16'h0001, 0, 16'h0008, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
